// File: rtl/mouse_input_conditioner_pkg.sv
// Shared types and constants for the mouse input conditioner: quadrature phase
// states, decoded step kinds and the post-reset warm-up length.
package mouse_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_t;

  localparam int WARMUP_CYCLES = 3;

  // Position of a phase state around the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] quad_pos(input quad_t q);
    logic [1:0] p;
    case (q)
      Q00:     p = 2'd0;
      Q01:     p = 2'd1;
      Q11:     p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  function automatic step_t quad_step(input quad_t prev, input quad_t cur);
    logic [1:0] d;
    step_t      s;
    d = quad_pos(cur) - quad_pos(prev);
    case (d)
      2'd0:    s = STEP_NONE;
      2'd1:    s = STEP_INC;
      2'd3:    s = STEP_DEC;
      default: s = STEP_ERR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mouse_input_conditioner_if.sv
// Raw mouse inputs, position load and conditioned outputs of the conditioner.
interface mouse_input_conditioner_if #(
  parameter int X_WIDTH = 16
);
  logic               button_raw;
  logic               quad_a;
  logic               quad_b;
  logic               x_load;
  logic [X_WIDTH-1:0] x_load_value;
  logic               mouse_pressed_;
  logic [X_WIDTH-1:0] mouse_x;
  logic               moved;
  logic               quad_error;
  logic [7:0]         error_count;

  modport master (
    output button_raw, quad_a, quad_b, x_load, x_load_value,
    input  mouse_pressed_, mouse_x, moved, quad_error, error_count
  );

  modport slave (
    input  button_raw, quad_a, quad_b, x_load, x_load_value,
    output mouse_pressed_, mouse_x, moved, quad_error, error_count
  );
endinterface

// File: rtl/mouse_input_conditioner_sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter: a new synced level is
// accepted only after it has differed from the output for DEBOUNCE_CYCLES cycles.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_,
  input  logic i_raw,
  output logic o_level
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_level   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
      if (r_sync_p1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
        r_level <= r_sync_p1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/mouse_input_conditioner.sv
// Mouse front end: synchronised/debounced button plus quadrature decode into a
// saturating, loadable X position with step and error reporting.
module mouse_input_conditioner
  import mouse_pkg::*;
#(
  parameter int                 X_WIDTH         = 16,
  parameter logic [X_WIDTH-1:0] X_MAX           = {X_WIDTH{1'b1}},
  parameter logic [X_WIDTH-1:0] X_RESET         = '0,
  parameter int                 DEBOUNCE_CYCLES = 1024
) (
  input logic                      clock,
  input logic                      reset_,
  mouse_input_conditioner_if.slave bus
);
  localparam int                WARM_W    = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARMUP_CYCLES);

  logic [1:0]         r_ab_p0;
  logic [1:0]         r_ab_p1;
  quad_t              r_prev_ab;
  logic [WARM_W-1:0]  r_warm;
  logic [X_WIDTH-1:0] r_x;
  logic               r_moved;
  logic               r_qerr;
  logic [7:0]         r_err_cnt;

  step_t              w_step;
  logic [X_WIDTH-1:0] w_x_next;
  logic               w_pressed;

  function automatic logic [X_WIDTH-1:0] clamp_load(input logic [X_WIDTH-1:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [X_WIDTH-1:0] sat_step(input logic [X_WIDTH-1:0] x,
                                                  input step_t              s);
    logic [X_WIDTH-1:0] y;
    y = x;
    case (s)
      STEP_INC: if (x < X_MAX) y = x + X_WIDTH'(1);
      STEP_DEC: if (x != '0)   y = x - X_WIDTH'(1);
      default:  y = x;
    endcase
    return y;
  endfunction

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clock  (clock),
    .reset_ (reset_),
    .i_raw  (bus.button_raw),
    .o_level(w_pressed)
  );

  // Stage p1 -> output: decode synced AB against the previous sample.
  always_comb begin
    w_step = STEP_NONE;
    if (r_warm == WARM_DONE) begin
      w_step = quad_step(r_prev_ab, quad_t'(r_ab_p1));
    end
    w_x_next = bus.x_load ? clamp_load(bus.x_load_value) : sat_step(r_x, w_step);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_ab_p0   <= 2'b00;
      r_ab_p1   <= 2'b00;
      r_prev_ab <= Q00;
      r_warm    <= '0;
      r_x       <= X_RESET;
      r_moved   <= 1'b0;
      r_qerr    <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_ab_p0   <= {bus.quad_a, bus.quad_b};
      r_ab_p1   <= r_ab_p0;
      r_prev_ab <= quad_t'(r_ab_p1);
      if (r_warm != WARM_DONE) begin
        r_warm <= r_warm + WARM_W'(1);
      end
      r_x     <= w_x_next;
      r_moved <= (w_x_next != r_x);
      r_qerr  <= (w_step == STEP_ERR);
      if ((w_step == STEP_ERR) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.mouse_pressed_ = w_pressed;
  assign bus.mouse_x        = r_x;
  assign bus.moved          = r_moved;
  assign bus.quad_error     = r_qerr;
  assign bus.error_count    = r_err_cnt;

endmodule

// File: tb/tb_mouse_input_conditioner.sv
// Self-checking bench for mouse_input_conditioner: vector table, hand-written
// latency/reset sequences and a randomized run against a history-based model.
module tb_mouse_input_conditioner;
  localparam int XW   = 16;
  localparam int XMAX = 100;
  localparam int XRST = 50;
  localparam int DEB  = 4;
  localparam int HN   = 8192;

  logic clock  = 1'b0;
  logic reset_ = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]    ab  = 2'b11;
  logic          btn = 1'b0;
  logic          ld  = 1'b0;
  logic [XW-1:0] val = '0;

  mouse_input_conditioner_if #(.X_WIDTH(XW)) bus ();

  assign {bus.quad_a, bus.quad_b} = ab;
  assign bus.button_raw           = btn;
  assign bus.x_load               = ld;
  assign bus.x_load_value         = val;

  mouse_input_conditioner #(
    .X_WIDTH        (XW),
    .X_MAX          (16'd100),
    .X_RESET        (16'd50),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the raw input history since reset.
  logic [1:0] h_ab  [HN];
  logic       h_btn [HN];
  int k = 0;
  int m_x = XRST, m_cnt = 0;
  bit m_moved = 0, m_qerr = 0, m_pr = 0;

  function automatic int ab_at(input int j);
    return (j >= 1) ? int'(h_ab[j % HN]) : 0;
  endfunction

  function automatic bit btn_at(input int j);
    return (j >= 1) ? h_btn[j % HN] : 1'b0;
  endfunction

  always @(posedge clock or negedge reset_) begin
    int p, c, nx;
    bit inc, dec, err, all;
    if (!reset_) begin
      k = 0; m_x = XRST; m_moved = 0; m_qerr = 0; m_cnt = 0; m_pr = 0;
    end else begin
      k++;
      h_ab[k % HN]  = {bus.quad_a, bus.quad_b};
      h_btn[k % HN] = bus.button_raw;
      c = ab_at(k - 2);
      p = ab_at(k - 3);
      inc = 0; dec = 0; err = 0;
      if (k >= 4) begin
        inc = (p == 0 && c == 1) || (p == 1 && c == 3) || (p == 3 && c == 2) || (p == 2 && c == 0);
        dec = (c == 0 && p == 1) || (c == 1 && p == 3) || (c == 3 && p == 2) || (c == 2 && p == 0);
        err = ((p ^ c) == 3);
      end
      if (bus.x_load)                nx = (int'(bus.x_load_value) > XMAX) ? XMAX : int'(bus.x_load_value);
      else if (inc && m_x < XMAX)    nx = m_x + 1;
      else if (dec && m_x > 0)       nx = m_x - 1;
      else                           nx = m_x;
      m_moved = (nx != m_x);
      m_x     = nx;
      m_qerr  = err;
      if (err && m_cnt < 255) m_cnt++;
      all = (k >= DEB);
      for (int j = k - DEB + 1; j <= k; j++) begin
        if (btn_at(j - 2) == m_pr) all = 0;
      end
      if (all) m_pr = ~m_pr;
    end
  end

  always @(negedge clock) begin
    if (reset_ && k > 0) begin
      chk("model mouse_x", int'(bus.mouse_x), m_x);
      chk("model moved", int'(bus.moved), int'(m_moved));
      chk("model quad_error", int'(bus.quad_error), int'(m_qerr));
      chk("model error_count", int'(bus.error_count), m_cnt);
      chk("model pressed", int'(bus.mouse_pressed_), int'(m_pr));
    end
  end

  typedef struct {
    logic [1:0] ab;
    bit         btn;
    bit         ld;
    int         val;
    int         hold;
    int         x;
    int         mv;
    int         er;
    int         cnt;
    bit         pr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] a, input bit b, input bit l, input int v, input int h,
                     input int x, input int mv, input int er, input int cnt, input bit pr);
    vec_t e;
    e.ab = a; e.btn = b; e.ld = l; e.val = v; e.hold = h;
    e.x = x; e.mv = mv; e.er = er; e.cnt = cnt; e.pr = pr;
    tbl.push_back(e);
  endtask

  function automatic logic [1:0] next_ab(input logic [1:0] a, input bit up);
    logic [1:0] n;
    case (a)
      2'b00:   n = up ? 2'b01 : 2'b10;
      2'b01:   n = up ? 2'b11 : 2'b00;
      2'b11:   n = up ? 2'b10 : 2'b01;
      default: n = up ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, " mouse_x"}, int'(bus.mouse_x), XRST);
    chk({tag, " moved"}, int'(bus.moved), 0);
    chk({tag, " quad_error"}, int'(bus.quad_error), 0);
    chk({tag, " error_count"}, int'(bus.error_count), 0);
    chk({tag, " pressed"}, int'(bus.mouse_pressed_), 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv, er, r;
    bit dir;
    logic [1:0] seq [4];

    // Reset released with AB=11: warm-up must hide the 00 -> 11 jump.
    ab = 2'b11; btn = 0; ld = 0; val = '0;
    repeat (3) @(negedge clock);
    chk_reset_values("reset");
    reset_ = 1'b1;
    mv = 0; er = 0;
    repeat (8) begin
      @(negedge clock);
      mv += int'(bus.moved);
      er += int'(bus.quad_error);
    end
    chk("warmup moved pulses", mv, 0);
    chk("warmup quad_error pulses", er, 0);
    chk("warmup mouse_x", int'(bus.mouse_x), XRST);
    chk("warmup error_count", int'(bus.error_count), 0);

    reset_ = 1'b0;
    ab = 2'b00;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;

    //  ab     btn ld val  hold x    mv er cnt pr
    add(2'b00, 0, 0,   0, 6, 50,  0, 0, 0, 0);
    add(2'b01, 0, 0,   0, 4, 51,  1, 0, 0, 0);
    add(2'b11, 0, 0,   0, 4, 52,  1, 0, 0, 0);
    add(2'b10, 0, 0,   0, 4, 53,  1, 0, 0, 0);
    add(2'b00, 0, 0,   0, 4, 54,  1, 0, 0, 0);
    add(2'b10, 0, 0,   0, 4, 53,  1, 0, 0, 0);
    add(2'b11, 0, 0,   0, 4, 52,  1, 0, 0, 0);
    add(2'b01, 0, 0,   0, 4, 51,  1, 0, 0, 0);
    add(2'b00, 0, 0,   0, 4, 50,  1, 0, 0, 0);
    add(2'b00, 0, 1,   1, 4,  1,  1, 0, 0, 0);
    add(2'b10, 0, 0,   0, 4,  0,  1, 0, 0, 0);
    add(2'b11, 0, 0,   0, 4,  0,  0, 0, 0, 0);
    add(2'b01, 0, 0,   0, 4,  0,  0, 0, 0, 0);
    add(2'b01, 0, 1, 200, 4, 100, 1, 0, 0, 0);
    add(2'b11, 0, 0,   0, 4, 100, 0, 0, 0, 0);
    add(2'b10, 0, 0,   0, 4, 100, 0, 0, 0, 0);
    add(2'b11, 0, 0,   0, 4, 99,  1, 0, 0, 0);
    add(2'b10, 0, 1,  30, 4, 30,  1, 0, 0, 0);
    add(2'b01, 0, 0,   0, 4, 30,  0, 1, 1, 0);
    add(2'b00, 0, 0,   0, 4, 29,  1, 0, 1, 0);
    add(2'b11, 0, 0,   0, 4, 29,  0, 1, 2, 0);
    add(2'b11, 1, 0,   0, 10, 29, 0, 0, 2, 1);
    add(2'b11, 0, 0,   0, 10, 29, 0, 0, 2, 0);
    add(2'b11, 1, 0,   0, 3, 29,  0, 0, 2, 0);
    add(2'b11, 0, 0,   0, 8, 29,  0, 0, 2, 0);

    foreach (tbl[i]) begin
      ab = tbl[i].ab; btn = tbl[i].btn; ld = tbl[i].ld; val = XW'(tbl[i].val);
      mv = 0; er = 0;
      repeat (tbl[i].hold) begin
        @(negedge clock);
        mv += int'(bus.moved);
        er += int'(bus.quad_error);
      end
      chk($sformatf("vec%0d mouse_x", i), int'(bus.mouse_x), tbl[i].x);
      chk($sformatf("vec%0d moved pulses", i), mv, tbl[i].mv);
      chk($sformatf("vec%0d quad_error pulses", i), er, tbl[i].er);
      chk($sformatf("vec%0d error_count", i), int'(bus.error_count), tbl[i].cnt);
      chk($sformatf("vec%0d pressed", i), int'(bus.mouse_pressed_), int'(tbl[i].pr));
    end

    // Steps held 2 cycles each: moved must pulse exactly 3 cycles after each edge.
    seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b01; seq[3] = 2'b11;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      chk($sformatf("latency moved@%0d", j), int'(bus.moved),
          (j >= 3 && ((j - 3) % 2) == 0 && (j - 3) < 8) ? 1 : 0);
      if ((j % 2) == 0 && j < 8) ab = seq[j / 2];
    end
    chk("latency final mouse_x", int'(bus.mouse_x), 33);

    @(negedge clock);
    btn = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clock);
      chk($sformatf("press latency@%0d", j), int'(bus.mouse_pressed_), (j >= 6) ? 1 : 0);
    end
    btn = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clock);
      chk($sformatf("release latency@%0d", j), int'(bus.mouse_pressed_), (j >= 6) ? 0 : 1);
    end

    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      ab = (ab == 2'b11) ? 2'b00 : 2'b11;
    end
    repeat (4) @(negedge clock);
    chk("saturated error_count", int'(bus.error_count), 255);
    chk("saturation mouse_x", int'(bus.mouse_x), 33);

    // Asynchronous reset in the middle of motion and of a debounce.
    btn = 1'b1;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ab = next_ab(ab, 1'b1);
    end
    btn = 1'b0;
    @(negedge clock);
    ab = next_ab(ab, 1'b1);
    @(negedge clock);
    chk("pre-reset pressed", int'(bus.mouse_pressed_), 1);
    #2 reset_ = 1'b0;
    #1 chk_reset_values("async reset");
    @(negedge clock);
    @(negedge clock);
    reset_ = 1'b1;

    dir = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      r = $urandom_range(0, 15);
      if (r < 8)       ab = next_ab(ab, dir);
      else if (r == 8) ab = ~ab;
      if ($urandom_range(0, 31) == 0) dir = ~dir;
      if ($urandom_range(0, 5) == 0)  btn = ~btn;
      ld = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 5))
        0:       val = 16'd0;
        1:       val = 16'd100;
        2:       val = 16'd101;
        3:       val = 16'd1;
        4:       val = 16'd99;
        default: val = XW'($urandom_range(0, 300));
      endcase
    end
    ld = 1'b0;
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
